// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with logic/shift/move ops, HI/LO and multiply.
// Define EX_DIV_EN to compile in the iterative divider; otherwise DIV/DIVU are NOPs.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_MOVZ_OP  = 8'b0000_1010;
    localparam logic [7:0] EXE_MOVN_OP  = 8'b0000_1011;
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;

    logic               kill;
    logic               is_div;
    logic [31:0]        hi;
    logic [31:0]        lo;
    logic signed [31:0] sra_res;
    logic signed [63:0] mult_s;
    logic [63:0]        mult_u;
    logic               div_wr;
    logic [31:0]        div_quo;
    logic [31:0]        div_rem;

    assign kill   = rst | flush_i;
    assign is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

    assign wd_o   = wd_i;
    assign wreg_o = kill ? 1'b0 : (is_div ? 1'b0 : wreg_i);
    assign hi_o   = hi;
    assign lo_o   = lo;

    assign sra_res = $signed(reg2_i) >>> reg1_i[4:0];
    assign mult_s  = $signed({{32{reg1_i[31]}}, reg1_i}) * $signed({{32{reg2_i[31]}}, reg2_i});
    assign mult_u  = {32'b0, reg1_i} * {32'b0, reg2_i};

    // Result mux is combinational so ID can forward it in the same cycle.
    always_comb begin
        wdata_o = '0;
        if (!kill) begin
            case (alusel_i)
                EXE_RES_LOGIC: begin
                    case (aluop_i)
                        EXE_OR_OP:  wdata_o = reg1_i | reg2_i;
                        EXE_AND_OP: wdata_o = reg1_i & reg2_i;
                        EXE_XOR_OP: wdata_o = reg1_i ^ reg2_i;
                        EXE_NOR_OP: wdata_o = ~(reg1_i | reg2_i);
                        default:    wdata_o = '0;
                    endcase
                end
                EXE_RES_SHIFT: begin
                    case (aluop_i)
                        EXE_SLL_OP: wdata_o = reg2_i << reg1_i[4:0];
                        EXE_SRL_OP: wdata_o = reg2_i >> reg1_i[4:0];
                        EXE_SRA_OP: wdata_o = sra_res;
                        default:    wdata_o = '0;
                    endcase
                end
                EXE_RES_MOVE: begin
                    case (aluop_i)
                        EXE_MFHI_OP: wdata_o = hi;
                        EXE_MFLO_OP: wdata_o = lo;
                        EXE_MOVN_OP: wdata_o = reg1_i;
                        EXE_MOVZ_OP: wdata_o = reg1_i;
                        default:     wdata_o = '0;
                    endcase
                end
                default: wdata_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (!flush_i) begin
            if (div_wr) begin
                hi <= div_rem;
                lo <= div_quo;
            end else begin
                case (aluop_i)
                    EXE_MTHI_OP:  hi <= reg1_i;
                    EXE_MTLO_OP:  lo <= reg1_i;
                    EXE_MULT_OP:  {hi, lo} <= mult_s;
                    EXE_MULTU_OP: {hi, lo} <= mult_u;
                    default: ;
                endcase
            end
        end
    end

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {IDLE, DIVIDING, DONE} div_state_t;

    div_state_t  state;
    div_state_t  state_next;
    logic [5:0]  cnt;
    logic [64:0] work;
    logic [64:0] work_next;
    logic [33:0] trial;
    logic [31:0] divisor;
    logic        neg_quo;
    logic        neg_rem;
    logic        load;
    logic        is_signed;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    assign is_signed = (aluop_i == EXE_DIV_OP);

    // work = {partial remainder[64:32], dividend/quotient[31:0]}; trial compares the shifted remainder.
    assign trial     = work[64:31] - {2'b00, divisor};
    assign work_next = trial[33] ? {work[63:0], 1'b0} : {trial[32:0], work[30:0], 1'b1};

    assign div_quo = neg_if(work[31:0], neg_quo);
    assign div_rem = neg_if(work[63:32], neg_rem);

    always_comb begin
        state_next = state;
        stallreq_o = 1'b0;
        div_wr     = 1'b0;
        load       = 1'b0;
        if (kill) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (is_div) begin
                        stallreq_o = 1'b1;
                        load       = 1'b1;
                        state_next = (reg2_i == 32'd0) ? DONE : DIVIDING;
                    end
                end
                DIVIDING: begin
                    stallreq_o = 1'b1;
                    if (cnt == 6'd31) state_next = DONE;
                end
                DONE: begin
                    div_wr     = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (load)
                cnt <= '0;
            else if (state == DIVIDING)
                cnt <= cnt + 6'd1;
        end
    end

    // Datapath registers carry no reset; they are always loaded before DONE reads them.
    always_ff @(posedge clk) begin
        if (load) begin
            work    <= (reg2_i == 32'd0) ? 65'd0 : {33'd0, abs32(reg1_i, is_signed)};
            divisor <= abs32(reg2_i, is_signed);
            neg_quo <= is_signed & (reg1_i[31] ^ reg2_i[31]);
            neg_rem <= is_signed & reg1_i[31];
        end else if (state == DIVIDING) begin
            work <= work_next;
        end
    end
`else
    assign stallreq_o = 1'b0;
    assign div_wr     = 1'b0;
    assign div_quo    = '0;
    assign div_rem    = '0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: table-driven scoreboard bench for ex_stage plus divider sequences
// (divider checks depend on whether EX_DIV_EN is defined).
module tb_ex_stage;
    localparam logic [7:0] AND_OP   = 8'b0010_0100;
    localparam logic [7:0] OR_OP    = 8'b0010_0101;
    localparam logic [7:0] XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] MOVZ_OP  = 8'b0000_1010;
    localparam logic [7:0] MOVN_OP  = 8'b0000_1011;
    localparam logic [7:0] MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] DIVU_OP  = 8'b0001_1011;
    localparam logic [7:0] NOP_OP   = 8'b0000_0000;
    localparam logic [2:0] R_NOP    = 3'b000;
    localparam logic [2:0] R_LOGIC  = 3'b001;
    localparam logic [2:0] R_SHIFT  = 3'b010;
    localparam logic [2:0] R_MOVE   = 3'b011;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic [31:0] hi_o, lo_o;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic        fl;
        logic [31:0] e_wdata;
        logic        e_wreg;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] wdata;
        logic        wreg;
        logic [4:0]  wd;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    ex_stage dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [4:0] wd, input logic wr, input logic fl);
        aluop_i = op; alusel_i = sel; reg1_i = r1; reg2_i = r2;
        wd_i = wd; wreg_i = wr; flush_i = fl;
    endtask

    task automatic add(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] wd, input logic wr, input logic fl,
                       input logic [31:0] e_wdata, input logic e_wreg,
                       input logic [31:0] e_hi, input logic [31:0] e_lo);
        vec_t v;
        v.op = op; v.sel = sel; v.r1 = r1; v.r2 = r2; v.wd = wd; v.wreg = wr; v.fl = fl;
        v.e_wdata = e_wdata; v.e_wreg = e_wreg; v.e_hi = e_hi; v.e_lo = e_lo;
        tbl.push_back(v);
    endtask

    // Drives a divide at posedge+1 and counts stall cycles until DONE; flush_cyc<0 means no flush.
    task automatic div_seq(input string name, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int flush_cyc, input int exp_stall,
                           input logic [31:0] e_hi, input logic [31:0] e_lo);
        int   n;
        logic done;
        n = 0;
        done = 1'b0;
        drive(op, R_NOP, a, b, 5'd4, 1'b1, 1'b0);
        for (int c = 0; c < 100 && !done; c++) begin
            if (c == flush_cyc) flush_i = 1'b1;
            @(negedge clk);
            if (c == 0) check({name, "_wreg"}, {31'b0, wreg_o}, 32'd0);
            if (stallreq_o) n++;
            else done = 1'b1;
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        check({name, "_done"}, {31'b0, done}, 32'd1);
        check({name, "_stall_cycles"}, n, exp_stall);
        @(posedge clk); #1;
        drive(NOP_OP, R_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check({name, "_hi"}, hi_o, e_hi);
        check({name, "_lo"}, lo_o, e_lo);
        check({name, "_stall_after"}, {31'b0, stallreq_o}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        int   n;

        rst = 1'b1;
        drive(OR_OP, R_LOGIC, 32'hF0F0_0000, 32'h0000_FFFF, 5'd7, 1'b1, 1'b0);
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_wreg", {31'b0, wreg_o}, 32'd0);
        check("rst_wdata", wdata_o, 32'd0);
        check("rst_wd", {27'b0, wd_o}, 32'd7);
        check("rst_stall", {31'b0, stallreq_o}, 32'd0);
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        add(OR_OP,  R_LOGIC, 32'hF0F0_0000, 32'h0000_FFFF, 5'd5, 1, 0, 32'hF0F0_FFFF, 1, 32'h0, 32'h0);
        add(AND_OP, R_LOGIC, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd1, 1, 0, 32'h00F0_F000, 1, 32'h0, 32'h0);
        add(XOR_OP, R_LOGIC, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd2, 1, 0, 32'hFF00_0FF0, 1, 32'h0, 32'h0);
        add(NOR_OP, R_LOGIC, 32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd3, 1, 0, 32'h000F_000F, 1, 32'h0, 32'h0);
        add(SRA_OP, R_SHIFT, 32'd4, 32'h8000_0000, 5'd6, 1, 0, 32'hF800_0000, 1, 32'h0, 32'h0);
        add(SRL_OP, R_SHIFT, 32'd4, 32'h8000_0000, 5'd6, 1, 0, 32'h0800_0000, 1, 32'h0, 32'h0);
        add(SLL_OP, R_SHIFT, 32'd31, 32'h0000_0001, 5'd6, 1, 0, 32'h8000_0000, 1, 32'h0, 32'h0);
        add(SRA_OP, R_SHIFT, 32'h24, 32'h7FFF_FFF0, 5'd6, 1, 0, 32'h07FF_FFFF, 1, 32'h0, 32'h0);
        add(MTHI_OP, R_NOP, 32'h1234_5678, 32'h0, 5'd0, 0, 0, 32'h0, 0, 32'h0, 32'h0);
        add(MFHI_OP, R_MOVE, 32'h0, 32'h0, 5'd3, 1, 0, 32'h1234_5678, 1, 32'h1234_5678, 32'h0);
        add(MTLO_OP, R_NOP, 32'h9ABC_DEF0, 32'h0, 5'd0, 0, 0, 32'h0, 0, 32'h1234_5678, 32'h0);
        add(MFLO_OP, R_MOVE, 32'h0, 32'h0, 5'd8, 1, 0, 32'h9ABC_DEF0, 1, 32'h1234_5678, 32'h9ABC_DEF0);
        add(MTHI_OP, R_NOP, 32'h5555_5555, 32'h0, 5'd0, 1, 1, 32'h0, 0, 32'h1234_5678, 32'h9ABC_DEF0);
        add(MFHI_OP, R_MOVE, 32'h0, 32'h0, 5'd3, 1, 0, 32'h1234_5678, 1, 32'h1234_5678, 32'h9ABC_DEF0);
        add(OR_OP,  R_LOGIC, 32'hF0F0_0000, 32'h0000_FFFF, 5'd5, 1, 1, 32'h0, 0, 32'h1234_5678, 32'h9ABC_DEF0);
        add(MULT_OP, R_NOP, 32'hFFFF_FFFD, 32'd7, 5'd0, 0, 0, 32'h0, 0, 32'h1234_5678, 32'h9ABC_DEF0);
        add(MFHI_OP, R_MOVE, 32'h0, 32'h0, 5'd3, 1, 0, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        add(MFLO_OP, R_MOVE, 32'h0, 32'h0, 5'd3, 1, 0, 32'hFFFF_FFEB, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        add(MULTU_OP, R_NOP, 32'hFFFF_FFFF, 32'd2, 5'd0, 0, 0, 32'h0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        add(MFHI_OP, R_MOVE, 32'h0, 32'h0, 5'd3, 1, 0, 32'h0000_0001, 1, 32'h0000_0001, 32'hFFFF_FFFE);
        add(MFLO_OP, R_MOVE, 32'h0, 32'h0, 5'd3, 1, 0, 32'hFFFF_FFFE, 1, 32'h0000_0001, 32'hFFFF_FFFE);
        add(MOVN_OP, R_MOVE, 32'hDEAD_BEEF, 32'h1, 5'd9, 1, 0, 32'hDEAD_BEEF, 1, 32'h0000_0001, 32'hFFFF_FFFE);
        add(MOVZ_OP, R_MOVE, 32'hCAFE_F00D, 32'h1, 5'd9, 0, 0, 32'hCAFE_F00D, 0, 32'h0000_0001, 32'hFFFF_FFFE);
        add(NOP_OP, R_NOP, 32'h0000_FFFF, 32'hFFFF_0000, 5'd2, 0, 0, 32'h0, 0, 32'h0000_0001, 32'hFFFF_FFFE);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            drive(tbl[i].op, tbl[i].sel, tbl[i].r1, tbl[i].r2, tbl[i].wd, tbl[i].wreg, tbl[i].fl);
            e.idx = i; e.wdata = tbl[i].e_wdata; e.wreg = tbl[i].e_wreg;
            e.wd = tbl[i].wd; e.hi = tbl[i].e_hi; e.lo = tbl[i].e_lo;
            exp_q.push_back(e);
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("v%0d_wdata", e.idx), wdata_o, e.wdata);
            check($sformatf("v%0d_wreg", e.idx), {31'b0, wreg_o}, {31'b0, e.wreg});
            check($sformatf("v%0d_wd", e.idx), {27'b0, wd_o}, {27'b0, e.wd});
            check($sformatf("v%0d_hi", e.idx), hi_o, e.hi);
            check($sformatf("v%0d_lo", e.idx), lo_o, e.lo);
        end
        @(posedge clk); #1;

`ifdef EX_DIV_EN
        div_seq("div_m7_2", DIV_OP, 32'hFFFF_FFF9, 32'd2, -1, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        div_seq("divu_100_7", DIVU_OP, 32'd100, 32'd7, -1, 33, 32'd2, 32'd14);
        div_seq("div_flush", DIV_OP, 32'd50, 32'd3, 10, 10, 32'd2, 32'd14);
        div_seq("div_m50_3", DIV_OP, 32'hFFFF_FFCE, 32'd3, -1, 33, 32'hFFFF_FFFE, 32'hFFFF_FFF0);
        div_seq("divu_by0", DIVU_OP, 32'd5, 32'd0, -1, 1, 32'd0, 32'd0);
        div_seq("divu_big", DIVU_OP, 32'hFFFF_FFFF, 32'h8000_0000, -1, 33, 32'h7FFF_FFFF, 32'd1);
        div_seq("div_min_m1", DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, -1, 33, 32'd0, 32'h8000_0000);
        div_seq("divu_pre_rst", DIVU_OP, 32'd100, 32'd7, -1, 33, 32'd2, 32'd14);

        drive(DIV_OP, R_NOP, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_div_stall", {31'b0, stallreq_o}, 32'd0);
        check("rst_mid_div_wreg", {31'b0, wreg_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(NOP_OP, R_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("rst_mid_div_hi", hi_o, 32'd0);
        check("rst_mid_div_lo", lo_o, 32'd0);
        check("rst_mid_div_stall_after", {31'b0, stallreq_o}, 32'd0);
        @(posedge clk); #1;
        div_seq("divu_post_rst", DIVU_OP, 32'd100, 32'd7, -1, 33, 32'd2, 32'd14);
`else
        drive(DIVU_OP, R_NOP, 32'd100, 32'd7, 5'd4, 1'b1, 1'b0);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 0) check("nodiv_wreg", {31'b0, wreg_o}, 32'd0);
            if (stallreq_o) n++;
            @(posedge clk); #1;
        end
        check("nodiv_stall_cycles", n, 0);
        drive(NOP_OP, R_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("nodiv_hi", hi_o, 32'h0000_0001);
        check("nodiv_lo", lo_o, 32'hFFFF_FFFE);
        @(posedge clk); #1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline. It consumes the decoded operation (aluop/alusel, two 32-bit operands, destination, write enable) from the ID/EX register and produces the register-write result that feeds both EX/MEM and the ID stage's EX-forwarding inputs. It owns the architectural HI/LO registers and contains a multi-cycle iterative divider that stalls the pipeline while it runs.

## Interface
- Parameters: none. Opcode values come from the shared define file: EXE_*_OP for aluop and EXE_RES_* for alusel.
- Ports:
  - clk  in  1  rising-edge clock
  - rst  in  1  reset, synchronous, active-high
  - flush_i  in  1  discard the current instruction and abort any divide in progress
  - aluop_i  in  8  operation code
  - alusel_i  in  3  result class: LOGIC, SHIFT, MOVE, NOP
  - reg1_i  in  32  operand 1: rs value or immediate
  - reg2_i  in  32  operand 2: rt value or immediate
  - wd_i  in  5  destination register address
  - wreg_i  in  1  destination write enable
  - wd_o  out  5  destination register address, equal to wd_i
  - wreg_o  out  1  write enable to EX/MEM and to ID forwarding
  - wdata_o  out  32  result
  - stallreq_o  out  1  divider busy; upstream holds all inputs stable
  - hi_o  out  32  current HI, for debug and bench use
  - lo_o  out  32  current LO, for debug and bench use

## Operation
- wd_o, wreg_o and wdata_o are combinational from the inputs and HI/LO, so ID can forward in the same cycle.
- When rst=1 or flush_i=1, wreg_o=0 and wdata_o=0.
- LOGIC class: OR, AND, XOR, NOR on reg1_i and reg2_i.
- SHIFT class: SLL, SRL, SRA of reg2_i by reg1_i[4:0]. SRA sign-fills.
- MOVE class:
  - MFHI returns HI; MFLO returns LO.
  - MOVN and MOVZ return reg1_i; wreg_i already encodes the condition.
- NOP class: wdata_o=0.
- HI/LO writes happen at the clock edge; no write occurs when flush_i=1.
  - MTHI: HI<=reg1_i. MTLO: LO<=reg1_i.
  - MULT (signed) and MULTU: {HI,LO}<=reg1_i*reg2_i as a full 64-bit product, in a single cycle.
- Divider FSM, states IDLE, DIVIDING, DONE:
  - IDLE, aluop is DIV or DIVU, divisor nonzero: latch |dividend| and |divisor| (raw values for DIVU) and go to DIVIDING. stallreq_o=1.
  - IDLE, divisor zero: go straight to DONE with quotient=0 and remainder=0. stallreq_o=1.
  - DIVIDING: one restoring shift-subtract step per cycle using a 6-bit counter and a 65-bit working register. After 32 steps go to DONE. stallreq_o=1.
  - DONE: stallreq_o=0, write LO<=quotient and HI<=remainder, return to IDLE.
  - Signed sign fix: quotient is negated when the operand signs differ; remainder takes the dividend's sign.
  - Divide instructions give wreg_o=0.
- flush_i=1 in any divider state: next state IDLE, no HI/LO write, stallreq_o=0 that cycle.

## Timing
- Reset values: HI=0, LO=0, FSM in IDLE, stallreq_o=0, wreg_o=0, wdata_o=0, wd_o=wd_i.
- Non-divide operations: zero-latency result; a HI/LO write is visible to MFHI in the next instruction.
- Nonzero divide, with cycle 0 being the first cycle the instruction is in EX:
  - stallreq_o=1 in cycles 0 through 32.
  - DONE in cycle 33; HI/LO are updated at the end of cycle 33.
  - The next instruction enters in cycle 34.
- Divide by zero: DONE in cycle 1; HI=LO=0 at the end of cycle 1.
- No re-trigger: the FSM leaves DONE at the same edge the instruction leaves EX.
- rst takes precedence over flush_i. rst mid-divide restores the reset state on the next edge.

## Configuration
- EX_DIV_EN defined: the divider FSM is compiled in and behaves as described above.
- EX_DIV_EN undefined:
  - DIV and DIVU act as NOP: no HI/LO change and wreg_o=0.
  - stallreq_o is tied to 0 and the FSM logic is absent.

## Test plan
- OR with reg1=32'hF0F0_0000, reg2=32'h0000_FFFF, wreg_i=1, wd_i=5 -> same cycle wdata_o=32'hF0F0_FFFF, wreg_o=1, wd_o=5.
- SRA with reg2=32'h8000_0000, reg1=4 -> wdata_o=32'hF800_0000; SRL with the same operands -> 32'h0800_0000.
- MULT with reg1=-3, reg2=7, then MFHI and MFLO -> HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB.
- DIV with reg1=-7, reg2=2 (EX_DIV_EN defined) -> stallreq_o high for exactly 33 cycles; then LO=32'hFFFF_FFFD and HI=32'hFFFF_FFFF. DIVU with 100/7 -> LO=14, HI=2.
- DIVU by 0 -> stallreq_o high for 1 cycle, then HI=LO=0. Without EX_DIV_EN, DIVU 100/7 -> stallreq_o never asserts and HI/LO are unchanged.
- DIV started, then flush_i asserted in cycle 10 -> stallreq_o=0 that cycle, HI/LO unchanged, the next DIV runs the full 34-cycle sequence (33 stall cycles plus DONE).
